// File: rtl/ift_sram_port_arbiter.sv
// Multi-port SRAM front end with round-robin arbitration, byte-granular taint tracking
// and an end-of-benchmark MMIO write decode.
module ift_sram_port_arbiter #(
    parameter int NumPorts = 2,
    parameter int NumWords = 1 << 17,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 64,
    parameter logic [AddrWidth-1:0] RelocBase = 32'h80000000,
    parameter logic [AddrWidth-1:0] MmioAddr = 32'h00010000,
    localparam int StrbWidth = DataWidth / 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumPorts-1:0]             req_i,
    input  logic [NumPorts-1:0]             req_i_t0,
    input  logic [NumPorts-1:0]             we_i,
    input  logic [NumPorts-1:0]             we_i_t0,
    input  logic [NumPorts*AddrWidth-1:0]   addr_i,
    input  logic [NumPorts*AddrWidth-1:0]   addr_i_t0,
    input  logic [NumPorts*StrbWidth-1:0]   be_i,
    input  logic [NumPorts*StrbWidth-1:0]   be_i_t0,
    input  logic [NumPorts*DataWidth-1:0]   wdata_i,
    input  logic [NumPorts*DataWidth-1:0]   wdata_i_t0,
    output logic [NumPorts-1:0]             gnt_o,
    output logic [NumPorts-1:0]             gnt_o_t0,
    output logic [NumPorts-1:0]             rvalid_o,
    output logic [NumPorts-1:0]             rvalid_o_t0,
    output logic [NumPorts*DataWidth-1:0]   rdata_o,
    output logic [NumPorts*DataWidth-1:0]   rdata_o_t0,
    output logic [AddrWidth-2:0]            mmio_aw_addr_o,
    output logic                            mmio_aw_valid_o,
    output logic                            done_o
);

    localparam int PtrW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int IdxW    = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int OffBits = $clog2(StrbWidth);

    logic [AddrWidth-1:0] addr_a    [NumPorts];
    logic [AddrWidth-1:0] addr_t0_a [NumPorts];
    logic [StrbWidth-1:0] be_a      [NumPorts];
    logic [StrbWidth-1:0] be_t0_a   [NumPorts];
    logic [DataWidth-1:0] wdata_a   [NumPorts];
    logic [DataWidth-1:0] wdata_t0_a[NumPorts];

    for (genvar k = 0; k < NumPorts; k++) begin : g_unpack
        assign addr_a[k]     = addr_i[k*AddrWidth +: AddrWidth];
        assign addr_t0_a[k]  = addr_i_t0[k*AddrWidth +: AddrWidth];
        assign be_a[k]       = be_i[k*StrbWidth +: StrbWidth];
        assign be_t0_a[k]    = be_i_t0[k*StrbWidth +: StrbWidth];
        assign wdata_a[k]    = wdata_i[k*DataWidth +: DataWidth];
        assign wdata_t0_a[k] = wdata_i_t0[k*DataWidth +: DataWidth];
    end

    function automatic logic [PtrW-1:0] port_at(input logic [PtrW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NumPorts) s = s - NumPorts;
        return PtrW'(s);
    endfunction

    logic [PtrW-1:0]     rr_ptr;
    logic [PtrW-1:0]     sel;
    logic                acc;
    logic [NumPorts-1:0] gnt;

    // First requester at or after rr_ptr wins; nothing is granted while in reset.
    always_comb begin
        gnt = '0;
        sel = '0;
        acc = 1'b0;
        if (!rst_i) begin
            for (int i = 0; i < NumPorts; i++) begin
                if (!acc && req_i[port_at(rr_ptr, i)]) begin
                    acc = 1'b1;
                    sel = port_at(rr_ptr, i);
                end
            end
        end
        if (acc) gnt[sel] = 1'b1;
    end

    assign gnt_o    = gnt;
    assign gnt_o_t0 = gnt & {NumPorts{|req_i_t0}};

    logic [AddrWidth-1:0] s_addr, s_addr_t0, s_off, s_idx;
    logic [StrbWidth-1:0] s_be, s_be_t0;
    logic [DataWidth-1:0] s_wdata, s_wdata_t0;
    logic                 s_we, s_we_t0, in_range, is_mmio, mem_wr, mem_rd, taint_force;
    logic [IdxW-1:0]      word;

    assign s_addr      = addr_a[sel];
    assign s_addr_t0   = addr_t0_a[sel];
    assign s_be        = be_a[sel];
    assign s_be_t0     = be_t0_a[sel];
    assign s_wdata     = wdata_a[sel];
    assign s_wdata_t0  = wdata_t0_a[sel];
    assign s_we        = we_i[sel];
    assign s_we_t0     = we_i_t0[sel];
    assign s_off       = s_addr - RelocBase;
    assign s_idx       = s_off >> OffBits;
    assign in_range    = (s_addr >= RelocBase) && (s_idx < AddrWidth'(NumWords));
    assign word        = s_idx[IdxW-1:0];
    assign is_mmio     = s_we && (s_addr == MmioAddr);
    assign mem_wr      = acc && s_we && !is_mmio && in_range;
    assign mem_rd      = acc && !s_we && in_range;
    assign taint_force = s_we_t0 || (|s_addr_t0);

    logic [DataWidth-1:0] mem_data  [NumWords];
    logic [DataWidth-1:0] mem_taint [NumWords];
    logic [DataWidth-1:0] rd_data_q, rd_taint_q;

    // Storage has no reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_wr) begin
            for (int b = 0; b < StrbWidth; b++) begin
                if (s_be[b]) begin
                    mem_data[word][b*8 +: 8]  <= s_wdata[b*8 +: 8];
                    mem_taint[word][b*8 +: 8] <= (s_be_t0[b] || taint_force) ? 8'hFF
                                                                            : s_wdata_t0[b*8 +: 8];
                end
            end
        end
        if (mem_rd) begin
            rd_data_q  <= mem_data[word];
            rd_taint_q <= mem_taint[word];
        end
    end

    logic [NumPorts-1:0] rsp_valid, rsp_gnt_t0;
    logic                rsp_hit, rsp_force;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr          <= '0;
            rsp_valid       <= '0;
            rsp_gnt_t0      <= '0;
            rsp_hit         <= 1'b0;
            rsp_force       <= 1'b0;
            mmio_aw_valid_o <= 1'b0;
            mmio_aw_addr_o  <= '0;
            done_o          <= 1'b0;
        end else begin
            rsp_valid       <= gnt;
            rsp_gnt_t0      <= gnt_o_t0;
            rsp_hit         <= mem_rd;
            rsp_force       <= taint_force;
            mmio_aw_valid_o <= acc && is_mmio;
            if (acc) rr_ptr <= (sel == PtrW'(NumPorts - 1)) ? '0 : sel + 1'b1;
            if (acc && is_mmio) begin
                mmio_aw_addr_o <= s_addr[AddrWidth-2:0];
                done_o         <= 1'b1;
            end
        end
    end

    // Writes, MMIO and out-of-range accesses respond with zero data and zero taint.
    logic [DataWidth-1:0] rsp_word, rsp_word_t0;
    assign rsp_word    = rsp_hit ? rd_data_q : '0;
    assign rsp_word_t0 = rsp_hit ? (rsp_force ? '1 : rd_taint_q) : '0;

    for (genvar k = 0; k < NumPorts; k++) begin : g_rsp
        assign rdata_o[k*DataWidth +: DataWidth]    = rsp_valid[k] ? rsp_word : '0;
        assign rdata_o_t0[k*DataWidth +: DataWidth] = rsp_valid[k] ? rsp_word_t0 : '0;
    end

    assign rvalid_o    = rsp_valid;
    assign rvalid_o_t0 = rsp_valid & rsp_gnt_t0;

endmodule

// File: tb/tb_ift_sram_port_arbiter.sv
// Directed bench for ift_sram_port_arbiter: a per-cycle reference model plus
// hand-computed literal expectations for the key scenarios.
module tb_ift_sram_port_arbiter;

    localparam int          NP     = 2;
    localparam longint      RELOC  = 64'h80000000;
    localparam longint      NWORDS = 64'd131072;
    localparam logic [31:0] MMIO   = 32'h00010000;

    logic         clk_i, rst_i;
    logic [1:0]   req, req_t0, we, we_t0;
    logic [63:0]  addr, addr_t0;
    logic [15:0]  be, be_t0;
    logic [127:0] wdata, wdata_t0;
    logic [1:0]   gnt_o, gnt_o_t0, rvalid_o, rvalid_o_t0;
    logic [127:0] rdata_o, rdata_o_t0;
    logic [30:0]  mmio_aw_addr_o;
    logic         mmio_aw_valid_o, done_o;

    int n_checks = 0;
    int n_fail   = 0;

    ift_sram_port_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_i(req), .req_i_t0(req_t0), .we_i(we), .we_i_t0(we_t0),
        .addr_i(addr), .addr_i_t0(addr_t0), .be_i(be), .be_i_t0(be_t0),
        .wdata_i(wdata), .wdata_i_t0(wdata_t0),
        .gnt_o(gnt_o), .gnt_o_t0(gnt_o_t0), .rvalid_o(rvalid_o), .rvalid_o_t0(rvalid_o_t0),
        .rdata_o(rdata_o), .rdata_o_t0(rdata_o_t0),
        .mmio_aw_addr_o(mmio_aw_addr_o), .mmio_aw_valid_o(mmio_aw_valid_o), .done_o(done_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (checked every negedge) ----------------
    logic [63:0] mem_d [int unsigned];
    logic [63:0] mem_t [int unsigned];
    bit          mem_k [int unsigned];

    bit          live = 0;
    int          m_rr = 0;
    logic [1:0]  e_rv = 0, e_rvt = 0;
    logic [63:0] e_rd = 0, e_rdt = 0;
    bit          e_known = 1;
    logic        e_mv = 0, e_done = 0;
    logic [30:0] e_ma = 0;

    always @(negedge clk_i) begin
        logic [1:0]   g;
        int           k;
        int           p;
        logic [127:0] xr, xt;
        logic [31:0]  a;
        longint       la;
        bit           inr, f;
        int unsigned  w;
        logic [63:0]  nd, nt;
        bit           ok;

        g = 2'b00;
        k = -1;
        if (!rst_i) begin
            for (int i = 0; i < NP; i++) begin
                p = (m_rr + i) % NP;
                if (k < 0 && req[p]) k = p;
            end
        end
        if (k >= 0) g[k] = 1'b1;

        if (live) begin
            check("gnt", gnt_o, g);
            check("gnt_t0", gnt_o_t0, (|req_t0) ? g : 2'b00);
            check("rvalid", rvalid_o, e_rv);
            check("rvalid_t0", rvalid_o_t0, e_rvt);
            if (e_known) begin
                xr = '0;
                xt = '0;
                for (int q = 0; q < NP; q++) begin
                    if (e_rv[q]) begin
                        xr[q*64 +: 64] = e_rd;
                        xt[q*64 +: 64] = e_rdt;
                    end
                end
                check("rdata", rdata_o, xr);
                check("rdata_t0", rdata_o_t0, xt);
            end
            check("mmio_valid", mmio_aw_valid_o, e_mv);
            check("mmio_addr", mmio_aw_addr_o, e_ma);
            check("done", done_o, e_done);
        end

        if (rst_i) begin
            live = 1; m_rr = 0; e_rv = 0; e_rvt = 0; e_rd = 0; e_rdt = 0;
            e_known = 1; e_mv = 0; e_ma = 0; e_done = 0;
        end else begin
            e_rv = g; e_rvt = (|req_t0) ? g : 2'b00;
            e_rd = 0; e_rdt = 0; e_known = 1; e_mv = 0;
            if (k >= 0) begin
                m_rr = (k + 1) % NP;
                a  = addr[k*32 +: 32];
                la = longint'(a);
                inr = (la >= RELOC) && ((la - RELOC) / 8 < NWORDS);
                w  = inr ? int'((la - RELOC) / 8) : 0;
                f  = we_t0[k] || (addr_t0[k*32 +: 32] != 0);
                if (we[k]) begin
                    if (a == MMIO) begin
                        e_mv = 1; e_ma = a[30:0]; e_done = 1;
                    end else if (inr) begin
                        nd = mem_d.exists(w) ? mem_d[w] : 64'h0;
                        nt = mem_t.exists(w) ? mem_t[w] : 64'h0;
                        ok = mem_k.exists(w) ? mem_k[w] : 1'b0;
                        for (int b = 0; b < 8; b++) begin
                            if (be[k*8+b]) begin
                                nd[b*8 +: 8] = wdata[k*64 + b*8 +: 8];
                                nt[b*8 +: 8] = (be_t0[k*8+b] || f) ? 8'hFF : wdata_t0[k*64 + b*8 +: 8];
                            end
                        end
                        mem_d[w] = nd; mem_t[w] = nt;
                        mem_k[w] = ok || (be[k*8 +: 8] == 8'hFF);
                    end
                end else if (inr) begin
                    if (mem_k.exists(w) && mem_k[w]) begin
                        e_rd  = mem_d[w];
                        e_rdt = f ? 64'hFFFF_FFFF_FFFF_FFFF : mem_t[w];
                    end else begin
                        e_known = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        req = 0; req_t0 = 0; we = 0; we_t0 = 0; addr = 0; addr_t0 = 0;
        be = 0; be_t0 = 0; wdata = 0; wdata_t0 = 0;
    endtask

    // One single-port request held for one cycle; returns at posedge+1 with the response visible.
    task automatic access(input int p, input logic w, input logic [31:0] a, input logic [7:0] b,
                          input logic [63:0] d, input logic [63:0] d_t0, input logic [7:0] b_t0,
                          input logic w_t0, input logic [31:0] a_t0, input logic r_t0);
        idle_inputs();
        req[p] = 1'b1; we[p] = w; we_t0[p] = w_t0; req_t0[p] = r_t0;
        addr[p*32 +: 32] = a; addr_t0[p*32 +: 32] = a_t0;
        be[p*8 +: 8] = b; be_t0[p*8 +: 8] = b_t0;
        wdata[p*64 +: 64] = d; wdata_t0[p*64 +: 64] = d_t0;
        @(posedge clk_i); #1;
        idle_inputs();
    endtask

    task automatic wr(input int p, input logic [31:0] a, input logic [7:0] b, input logic [63:0] d);
        access(p, 1'b1, a, b, d, 64'h0, 8'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rd(input int p, input logic [31:0] a);
        access(p, 1'b0, a, 8'h0, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    logic [1:0] exp_g [4];

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        req = 2'b11;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_gnt", gnt_o, 2'b00);
        check("reset_rvalid", rvalid_o, 2'b00);
        check("reset_done", done_o, 1'b0);
        check("reset_mmio_valid", mmio_aw_valid_o, 1'b0);
        check("reset_rdata", rdata_o, 128'h0);
        rst_i = 1'b0;
        idle_inputs();

        // partial byte-enable write over a zeroed word
        wr(0, 32'h80000008, 8'hFF, 64'h0);
        wr(0, 32'h80000008, 8'h0F, 64'h1122334455667788);
        rd(0, 32'h80000008);
        check("be_partial_data", rdata_o[63:0], 64'h0000000055667788);
        check("be_partial_taint", rdata_o_t0[63:0], 64'h0);

        // be_t0 taints one byte; tainted address taints the whole response
        access(1, 1'b1, 32'h80000010, 8'hFF, 64'hDEADBEEFCAFEF00D, 64'h0, 8'h01, 1'b0, 32'h0, 1'b0);
        rd(1, 32'h80000010);
        check("be_t0_data", rdata_o[127:64], 64'hDEADBEEFCAFEF00D);
        check("be_t0_taint", rdata_o_t0[127:64], 64'h00000000000000FF);
        access(1, 1'b0, 32'h80000010, 8'h0, 64'h0, 64'h0, 8'h0, 1'b0, 32'h4, 1'b0);
        check("addr_t0_taint", rdata_o_t0[127:64], 64'hFFFFFFFFFFFFFFFF);

        // wdata_t0 stored as-is; we_t0 forces enabled bytes
        access(0, 1'b1, 32'h80000018, 8'hFF, 64'h0102030405060708, 64'h0000FFFF00000000,
               8'h0, 1'b0, 32'h0, 1'b0);
        rd(0, 32'h80000018);
        check("wdata_t0_taint", rdata_o_t0[63:0], 64'h0000FFFF00000000);
        access(0, 1'b1, 32'h80000018, 8'h03, 64'hAAAAAAAAAAAAAAAA, 64'h0, 8'h0, 1'b1, 32'h0, 1'b0);
        rd(0, 32'h80000018);
        check("we_t0_data", rdata_o[63:0], 64'h010203040506AAAA);
        check("we_t0_taint", rdata_o_t0[63:0], 64'h0000FFFF0000FFFF);

        // tainted request propagates to the registered response valid
        access(0, 1'b0, 32'h80000018, 8'h0, 64'h0, 64'h0, 8'h0, 1'b0, 32'h0, 1'b1);
        check("req_t0_rvalid_t0", rvalid_o_t0, 2'b01);

        // end-of-benchmark MMIO write
        wr(0, MMIO, 8'hFF, 64'h1);
        check("mmio_valid_pulse", mmio_aw_valid_o, 1'b1);
        check("mmio_addr", mmio_aw_addr_o, 31'h00010000);
        check("mmio_done", done_o, 1'b1);
        check("mmio_rsp_data", rdata_o[63:0], 64'h0);
        @(posedge clk_i); #1;
        check("mmio_valid_drop", mmio_aw_valid_o, 1'b0);
        check("mmio_done_held", done_o, 1'b1);
        rd(0, 32'h80000008);
        check("mmio_sram_intact", rdata_o[63:0], 64'h0000000055667788);

        // out-of-range reads and writes, guarding words they could alias
        wr(0, 32'h80000000, 8'hFF, 64'h0F0F0F0F0F0F0F0F);
        wr(0, 32'h800FFFF8, 8'hFF, 64'hF0F0F0F0F0F0F0F0);
        rd(0, 32'h7FFFFFF8);
        check("oor_low_rvalid", rvalid_o, 2'b01);
        check("oor_low_data", rdata_o[63:0], 64'h0);
        rd(1, 32'h80100000);
        check("oor_high_rvalid", rvalid_o, 2'b10);
        check("oor_high_data", rdata_o[127:64], 64'h0);
        wr(0, 32'h7FFFFFF8, 8'hFF, 64'hBADBADBADBADBAD0);
        wr(1, 32'h80100000, 8'hFF, 64'hBADBADBADBADBAD1);
        rd(0, 32'h80000000);
        check("oor_word0_intact", rdata_o[63:0], 64'h0F0F0F0F0F0F0F0F);
        rd(0, 32'h800FFFF8);
        check("oor_last_intact", rdata_o[63:0], 64'hF0F0F0F0F0F0F0F0);

        // reset right after an accepted read, then both ports read continuously
        idle_inputs();
        req = 2'b01;
        addr[31:0] = 32'h80000008;
        @(posedge clk_i); #1;
        check("pre_reset_rvalid", rvalid_o, 2'b01);
        rst_i = 1'b1;
        req = 2'b11;
        addr[63:32] = 32'h80000010;
        @(posedge clk_i); #1;
        check("reset_drops_rvalid", rvalid_o, 2'b00);
        check("reset_blocks_gnt", gnt_o, 2'b00);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_gnt_%0d", i), gnt_o, exp_g[i]);
            if (i > 0) check($sformatf("rr_rvalid_%0d", i), rvalid_o, exp_g[i-1]);
            @(posedge clk_i); #1;
        end
        check("rr_last_rvalid", rvalid_o, 2'b10);
        check("rr_preserved_p1", rdata_o[127:64], 64'hDEADBEEFCAFEF00D);
        idle_inputs();
        @(posedge clk_i); #1;
        rd(0, 32'h80000008);
        check("reset_mem_preserved", rdata_o[63:0], 64'h0000000055667788);

        repeat (3) @(posedge clk_i);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ift_sram_port_arbiter.md
IFT_SRAM_PORT_ARBITER -- requirements
Module: ift_sram_port_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 2: number of requester ports, 1..8.
REQ-002 SHALL have parameter NumWords, default 1<<17: SRAM depth in words.
REQ-003 SHALL have parameter AddrWidth, default 32: byte-address width.
REQ-004 SHALL have parameter DataWidth, default 64: word width, a multiple of 8; StrbWidth = DataWidth/8.
REQ-005 SHALL have parameter RelocBase, default 32'h80000000: byte address of word 0.
REQ-006 SHALL have parameter MmioAddr, default 32'h00010000: end-of-benchmark write address.
REQ-007 SHALL have port clk_i, in, 1: the single clock; all logic is clocked on its rising edge.
REQ-008 SHALL have port rst_i, in, 1: synchronous, active-high reset.
REQ-009 SHALL have ports req_i / req_i_t0, in, NumPorts: per-port request and its taint.
REQ-010 SHALL have ports we_i / we_i_t0, in, NumPorts: per-port write enable and its taint.
REQ-011 SHALL have ports addr_i / addr_i_t0, in, NumPorts*AddrWidth: byte addresses and their taints.
REQ-012 SHALL have ports be_i / be_i_t0, in, NumPorts*StrbWidth: byte enables and their taints.
REQ-013 SHALL have ports wdata_i / wdata_i_t0, in, NumPorts*DataWidth: write data and its taint.
REQ-014 SHALL have ports gnt_o / gnt_o_t0, out, NumPorts: per-port grant and its taint.
REQ-015 SHALL have ports rvalid_o / rvalid_o_t0, out, NumPorts: per-port response valid and its taint.
REQ-016 SHALL have ports rdata_o / rdata_o_t0, out, NumPorts*DataWidth: read data and its taint.
REQ-017 SHALL have ports mmio_aw_addr_o, out, AddrWidth-1, and mmio_aw_valid_o, out, 1: end-of-benchmark signalling.
REQ-018 SHALL have port done_o, out, 1: sticky end-of-benchmark flag.

Function
REQ-019 SHALL grant at most one port per cycle, combinationally: gnt_o[k]=1 only while req_i[k]=1; a request is accepted when req_i & gnt_o.
REQ-020 SHALL arbitrate round-robin: the search starts at rr_ptr; after accepting port k, rr_ptr becomes (k+1) mod NumPorts; with no acceptance rr_ptr holds.
REQ-021 SHALL set gnt_o_t0[k] = gnt_o[k] & (OR of req_i_t0 over all ports).
REQ-022 SHALL compute word index = (addr - RelocBase) >> log2(StrbWidth); the access is in range iff addr >= RelocBase and index < NumWords.
REQ-023 SHALL, for an accepted in-range write, update each byte b with be[b]=1, writing both data and taint in the same cycle; bytes with be[b]=0 are unchanged.
REQ-024 SHALL set the stored taint of byte b to all-ones when be_t0[b]=1, or when we_t0=1, or when addr_t0 is nonzero, regardless of wdata_t0.
REQ-025 SHALL return read data with one-cycle latency: the cycle after an accepted read, rvalid_o[k]=1 for exactly one cycle with rdata_o[k] = stored word.
REQ-026 SHALL drive rdata_o_t0 = stored taint, forced to all-ones when addr_t0 or we_t0 of the accepted request was nonzero.
REQ-027 SHALL also pulse rvalid_o for accepted writes one cycle later, with rdata_o = 0 and rdata_o_t0 = 0.
REQ-028 SHALL drop out-of-range writes silently; out-of-range reads SHALL return rdata_o = 0, rdata_o_t0 = 0, with rvalid still asserted.
REQ-029 SHALL, for an accepted write with addr == MmioAddr, bypass the SRAM, register mmio_aw_addr_o = addr[AddrWidth-2:0], pulse mmio_aw_valid_o for one cycle the following cycle, and set done_o.
REQ-030 SHALL set rvalid_o_t0[k] = rvalid_o[k] & registered gnt_o_t0[k].
REQ-031 SHALL hold rdata_o and rdata_o_t0 at 0 for a port in every cycle its rvalid_o is 0.
REQ-032 SHALL, when read and write hit the same word in consecutive cycles, return the newly written value (write-first ordering through the array).

Reset
REQ-033 SHALL, with rst_i=1 at a clock edge: set rr_ptr=0, rvalid_o=0, mmio_aw_valid_o=0, mmio_aw_addr_o=0, done_o=0, and all *_t0 outputs=0.
REQ-034 SHALL drop any response pending at reset and accept no request while rst_i=1 (gnt_o=0).
REQ-035 SHALL leave the SRAM data and taint arrays unchanged across reset.

Verification
REQ-036 SHALL cover: ports 0 and 1 both request reads continuously from reset -> grants alternate 0,1,0,1; each rvalid arrives one cycle after its grant.
REQ-037 SHALL cover: write 0x1122334455667788 to 0x80000008 with be=0x0F, then read -> 0x0000000055667788 (prior zeros), taint 0.
REQ-038 SHALL cover: write with be_t0=0x01, then read the same word -> rdata_o_t0 = 0x00000000000000FF; a read with addr_t0 nonzero -> rdata_o_t0 = all-ones.
REQ-039 SHALL cover: write to 0x00010000 -> the next cycle mmio_aw_valid_o=1 for one cycle, mmio_aw_addr_o=0x00010000, done_o=1 and held; the SRAM is unchanged.
REQ-040 SHALL cover: a read at 0x7FFFFFF8 and a read at RelocBase+NumWords*8 -> rvalid=1 with rdata 0; a write to the same addresses leaves the SRAM unchanged.
REQ-041 SHALL cover: rst_i asserted the cycle after an accepted read -> no rvalid; afterwards rr_ptr=0 and memory contents preserved.
